ec1_out_port: RTL and testbench
===============================

// Module: ec1_out_port
// PURPOSE
//   Consumer end of the EC-1 control unit's OUT path. Every cycle OutE is high,
//   the current accumulator value is pushed into a small FIFO.
//   The FIFO is drained to an external display/host through a valid/ready handshake.
//   Reports fill level, a sticky overflow flag, and "done": the CPU has halted
//   and every OUT value has been delivered.
// PARAMETERS
//   WIDTH  8  data width; equals the accumulator width
//   DEPTH  4  FIFO entries; must be a power of 2 and >= 2
// PORTS
//   clk        in   1                   system clock; all state updates on posedge
//   Reset_n    in   1                   asynchronous, active-low reset
//   OutE       in   1                   push strobe from control unit (high in OUT state)
//   A_in       in   WIDTH               accumulator value, sampled when OutE=1
//   H          in   1                   halt indicator from control unit
//   out_data   out  WIDTH               head-of-FIFO data
//   out_valid  out  1                   out_data is valid (FIFO not empty)
//   out_ready  in   1                   sink accepts out_data this cycle
//   count      out  $clog2(DEPTH+1)     entries currently held
//   full       out  1                   count == DEPTH
//   overflow   out  1                   sticky: a push arrived while full with no pop
//   done       out  1                   H && count == 0
// BEHAVIOUR
//   - Reset (Reset_n=0, async): pointers=0, count=0, storage=0. All outputs 0:
//     out_data, out_valid, full, overflow, done. Reset mid-transfer discards all
//     contents immediately.
//   - Push: any posedge with OutE=1 writes A_in at the tail; tail ptr += 1 (mod DEPTH).
//   - Pop: any posedge with out_valid && out_ready; head ptr += 1 (mod DEPTH).
//   - First-word fall-through timing: push into empty FIFO at edge N gives
//     out_valid=1 and out_data=A_in right after edge N. Latency is 1 cycle.
//   - out_valid = (count != 0). The value is registered-equivalent and holds no
//     combinational path from OutE or out_ready.
//   - While out_valid && !out_ready, out_data and out_valid stay stable.
//     Exception: EC1_OUT_DROP_OLDEST_EN overwrite.
//   - Push and pop in the same cycle:
//     - count unchanged; both pointers advance.
//     - Also valid when full: the pop frees the slot, and overflow is not set.
//   - Push and pop in the same cycle when empty: no pop (out_valid=0); push proceeds.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked
//     separately, so full and empty are unambiguous.
//   - Push while full without pop: see CONFIGURATION. overflow <= 1 in both modes.
//     overflow clears only on reset.
//   - done is combinational from H and count. H may rise while entries remain;
//     done then rises on the edge that pops the last entry.
//   - Pushes after H are still accepted. The control unit never issues them.
// CONFIGURATION
//   Macro: EC1_OUT_DROP_OLDEST_EN
//   - Undefined (default): push while full without pop is dropped.
//     Storage, pointers and count are unchanged; only overflow is set.
//   - Defined: push while full without pop overwrites the oldest entry.
//     - A_in is written at the tail, and head and tail both advance.
//     - count stays DEPTH, and overflow is set.
//     - out_data changes to the next-oldest value even if out_valid && !out_ready.
//       The sink must tolerate this.
// TESTING
//   1 Reset: Reset_n=0 mid-stream with 3 entries held -> all outputs 0 at once,
//     with no clk edge needed.
//   2 Single push: OutE=1 with A_in=8'h5A, out_ready=0 -> next cycle
//     out_valid=1, out_data=5A, count=1. Hold 10 cycles, then stays stable.
//     Then out_ready=1 for 1 cycle -> count=0, out_valid=0.
//   3 Fill and wrap: push 01..04 (count=4, full=1).
//     Pop 2 (out_data 01, 02), push 05, 06, then drain.
//     -> sequence 01..06 in order, full=0, overflow=0.
//   4 Full push+pop: with full=1, OutE=1 (A_in=07) and out_ready=1 in the same cycle
//     -> count stays 4, overflow=0, 07 delivered last.
//   5 Overflow: full with 01..04, push 09, out_ready=0 -> overflow=1.
//     Default drains 01,02,03,04. With EC1_OUT_DROP_OLDEST_EN it drains 02,03,04,09.
//   6 Halt drain: H=1 with 2 entries -> done=0 until the second pop,
//     then done=1 from that edge onward.

Source files
------------

// File: rtl/ec1_out_port.sv
// EC-1 OUT path FIFO: buffers accumulator values pushed by OutE and drains them over valid/ready.
// Optional macro EC1_OUT_DROP_OLDEST_EN: a push into a full FIFO overwrites the oldest entry instead of being dropped.
module ec1_out_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       Reset_n,
  input  logic                       OutE,
  input  logic [WIDTH-1:0]           A_in,
  input  logic                       H,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic                       done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_en_s;
  logic             push_s, pop_s, full_s, valid_s;

  assign valid_s = (count_q != {CW{1'b0}});
  assign full_s  = (count_q == CNT_FULL);
  assign push_s  = OutE;
  assign pop_s   = valid_s && out_ready;

  // Next-state decode for pointers, occupancy and the sticky overflow flag
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    case ({push_s, pop_s})
      2'b11: begin
        // A pop frees the slot, so a full FIFO still accepts the push
        wr_en_s = 1'b1;
        tail_d  = tail_q + PTR_ONE;
        head_d  = head_q + PTR_ONE;
      end
      2'b10: begin
        if (!full_s) begin
          wr_en_s = 1'b1;
          tail_d  = tail_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
        end else begin
          overflow_d = 1'b1;
`ifdef EC1_OUT_DROP_OLDEST_EN
          wr_en_s = 1'b1;
          tail_d  = tail_q + PTR_ONE;
          head_d  = head_q + PTR_ONE;
`endif
        end
      end
      2'b01: begin
        head_d  = head_q + PTR_ONE;
        count_d = count_q - CNT_ONE;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // State registers and storage
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (wr_en_s) begin
        mem_q[tail_q] <= A_in;
      end
    end
  end

  assign out_data  = mem_q[head_q];
  assign out_valid = valid_s;
  assign count     = count_q;
  assign full      = full_s;
  assign overflow  = overflow_q;
  assign done      = H && !valid_s;

endmodule

// File: tb/tb_ec1_out_port.sv
// Self-checking bench for ec1_out_port: directed vector table, hand sequences, and random traffic against a queue model.
module tb_ec1_out_port;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             Reset_n;
  logic             OutE;
  logic [WIDTH-1:0] A_in;
  logic             H;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             overflow;
  logic             done;

  ec1_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .Reset_n(Reset_n), .OutE(OutE), .A_in(A_in), .H(H),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       oute;
    logic [7:0] a;
    logic       h;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_count;
    logic       e_done;
  } vec_t;

  vec_t       vecs[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] mq[$];
  logic       movf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic oute, input logic [7:0] a, input logic h, input logic rdy,
                     input logic ev, input logic [7:0] ed, input int ec, input logic edn);
    vec_t v;
    v.oute = oute; v.a = a; v.h = h; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_done = edn;
    vecs.push_back(v);
  endtask

  // Drive inputs for one cycle starting just after a negedge, return at the following negedge
  task automatic step(input logic oute, input logic [7:0] a, input logic h, input logic rdy);
    OutE = oute; A_in = a; H = h; out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_seq[4];
    logic       mpop;

    Reset_n = 1'b0; OutE = 1'b0; A_in = 8'h00; H = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    Reset_n = 1'b1;

    // Single push, hold, single pop
    add(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h5A, 1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    // Fill, partial drain, wrap, full drain
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1, 1'b0);
    add(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 2, 1'b0);
    add(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3, 1'b0);
    add(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 3, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 2, 1'b0);
    add(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h03, 3, 1'b0);
    add(1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h03, 4, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 3, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 2, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h06, 1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    // Full with simultaneous push and pop
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1, 1'b0);
    add(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 2, 1'b0);
    add(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3, 1'b0);
    add(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b0);
    add(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h02, 4, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 3, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 2, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h07, 1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    // Push with ready while empty: push only
    add(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    // Halt drain
    add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA, 1, 1'b0);
    add(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 8'hAA, 2, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 2, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hBB, 1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);

    foreach (vecs[k]) begin
      step(vecs[k].oute, vecs[k].a, vecs[k].h, vecs[k].rdy);
      chk($sformatf("v%0d_valid", k), {31'd0, out_valid}, {31'd0, vecs[k].e_valid});
      if (vecs[k].e_valid) chk($sformatf("v%0d_data", k), {24'd0, out_data}, {24'd0, vecs[k].e_data});
      chk($sformatf("v%0d_count", k), {29'd0, count}, vecs[k].e_count);
      chk($sformatf("v%0d_full", k), {31'd0, full}, {31'd0, (vecs[k].e_count == DEPTH)});
      chk($sformatf("v%0d_ovf", k), {31'd0, overflow}, 32'd0);
      chk($sformatf("v%0d_done", k), {31'd0, done}, {31'd0, vecs[k].e_done});
    end

    // Overflow: push into full FIFO without pop
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {29'd0, count}, 32'd4);
    chk("ovf_full", {31'd0, full}, 32'd1);
`ifdef EC1_OUT_DROP_OLDEST_EN
    exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h09;
`else
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h03; exp_seq[3] = 8'h04;
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), {24'd0, out_data}, {24'd0, exp_seq[i]});
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("ovf_empty", {31'd0, out_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Asynchronous reset mid-stream with 3 entries held
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    #1 Reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_full", {31'd0, full}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    Reset_n = 1'b1;

    // Random traffic against a queue model
    mq.delete();
    movf = 1'b0;
    for (int n = 0; n < 500; n++) begin
      OutE = ($urandom_range(0, 99) < 55);
      A_in = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 45);
      H = ($urandom_range(0, 3) == 0);
      mpop = (mq.size() != 0) && out_ready;
      if (mpop) void'(mq.pop_front());
      if (OutE) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(A_in);
        end else begin
          movf = 1'b1;
`ifdef EC1_OUT_DROP_OLDEST_EN
          void'(mq.pop_front());
          mq.push_back(A_in);
`endif
        end
      end
      @(posedge clk);
      @(negedge clk);
      chk("rnd_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
      if (mq.size() != 0) chk("rnd_data", {24'd0, out_data}, {24'd0, mq[0]});
      chk("rnd_count", {29'd0, count}, mq.size());
      chk("rnd_full", {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
      chk("rnd_ovf", {31'd0, overflow}, {31'd0, movf});
      chk("rnd_done", {31'd0, done}, {31'd0, (H && mq.size() == 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
